// File: rtl/valid_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// valid_scheduler_pkg
// Shared types and helpers for the valid scheduler:
//   state_e         - arbiter FSM states (IDLE / BUSY)
//   is_brdcst_addr  - true when an APB address selects the broadcast slot,
//                     which sits at index NSOURCES (one past the last source)
// -----------------------------------------------------------------------------
package valid_scheduler_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   // The broadcast slot lives directly above the last per-source address.
   function automatic logic is_brdcst_addr(input logic [31:0] addr,
                                           input logic [31:0] nsources);
      return (addr == nsources);
   endfunction

endpackage : valid_scheduler_pkg

// File: rtl/valid_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin search. Starting at last_i+1 and wrapping
// from N-1 back to 0, returns the first set bit of req_i.
//   req_i   in  N           request vector
//   last_i  in  $clog2(N)   index granted last time
//   idx_o   out $clog2(N)   first requesting index after last_i
//   found_o out 1           idx_o is valid (some request was set)
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]          req_i,
   input  logic [$clog2(N)-1:0]  last_i,
   output logic [$clog2(N)-1:0]  idx_o,
   output logic                  found_o
);

   localparam int IW = $clog2(N);

   // NOTE: every output gets a default before the search so no latch is inferred.
   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      // i runs 1..N so last_i itself is checked last (lowest priority).
      for (int i = 1; i <= N; i++) begin
         if (!found_o && req_i[(int'(last_i) + i) % N]) begin
            found_o = 1'b1;
            idx_o   = IW'((int'(last_i) + i) % N);
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/valid_scheduler.sv
// -----------------------------------------------------------------------------
// valid_scheduler
// Counts data-ready events per sink, grants sinks round-robin to the APB
// slave side, and decodes APB writes into per-source valid strobes.
//   pclk                    in  1          clock, rising edge
//   rstn                    in  1          async active-low reset
//   master_valids           in  NSINKS     per-sink data-ready request
//   paddr                   in  ADDR_WIDTH APB write address
//   slv0_wr                 in  1          write strobe to slave side
//   slv0_penable            in  1          APB enable, completes granted transfer
//   src_brdcst_subscription in  NSOURCES   broadcast membership per source
//   ovf_clr                 in  1          clears all overflow flags
//   current_idx             out $clog2(NSINKS) granted sink
//   grant_valid             out 1          current_idx is a live grant
//   valids_active           out NSINKS     sink has pending events
//   slave_valids            out NSOURCES   registered per-source write valid
//   overflow                out NSINKS     sticky pending-counter overflow
// -----------------------------------------------------------------------------
module valid_scheduler
   import valid_scheduler_pkg::*;
#(
   parameter int NSINKS     = 4,
   parameter int NSOURCES   = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int DEPTH      = 3,
   parameter int LEVEL_MODE = 0
) (
   input  logic                      pclk,
   input  logic                      rstn,
   input  logic [NSINKS-1:0]         master_valids,
   input  logic [ADDR_WIDTH-1:0]     paddr,
   input  logic                      slv0_wr,
   input  logic                      slv0_penable,
   input  logic [NSOURCES-1:0]       src_brdcst_subscription,
   input  logic                      ovf_clr,
   output logic [$clog2(NSINKS)-1:0] current_idx,
   output logic                      grant_valid,
   output logic [NSINKS-1:0]         valids_active,
   output logic [NSOURCES-1:0]       slave_valids,
   output logic [NSINKS-1:0]         overflow
);

   localparam int IW = $clog2(NSINKS);
   localparam int CW = $clog2(DEPTH + 1);

   logic [NSINKS-1:0]   mv_q;
   logic [CW-1:0]       count_q [NSINKS];
   logic [CW-1:0]       count_d [NSINKS];
   logic [NSINKS-1:0]   va_q, va_d;
   logic [NSINKS-1:0]   ovf_q, ovf_d;
   logic [NSINKS-1:0]   event_w, done_w;
   state_e              state_q, state_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [IW-1:0]       last_q, last_d;
   logic [NSOURCES-1:0] sv_q, sv_d;
   logic [IW-1:0]       rr_idx;
   logic                rr_found;

   // ---------------------------------------------------------------- events
   // Level mode re-arms only once the sink has drained, so a held request
   // produces one event per service rather than one per cycle.
   always_comb begin
      event_w = '0;
      done_w  = '0;
      for (int j = 0; j < NSINKS; j++) begin
         event_w[j] = (LEVEL_MODE != 0) ? (master_valids[j] & ~va_q[j])
                                        : (master_valids[j] & ~mv_q[j]);
         done_w[j]  = slv0_penable & (state_q == BUSY) & (idx_q == IW'(j));
      end
   end

   // ------------------------------------------------------ pending counters
   // Event and done together cancel; a saturated counter flags overflow
   // instead of wrapping, and the set term dominates ovf_clr.
   always_comb begin
      for (int j = 0; j < NSINKS; j++) begin
         count_d[j] = count_q[j];
         ovf_d[j]   = ovf_q[j] & ~ovf_clr;
         if (event_w[j] && !done_w[j]) begin
            if (count_q[j] == CW'(DEPTH)) begin
               ovf_d[j] = 1'b1;
            end else begin
               count_d[j] = count_q[j] + 1'b1;
            end
         end else if (done_w[j] && !event_w[j] && (count_q[j] != '0)) begin
            count_d[j] = count_q[j] - 1'b1;
         end
         // Registered from count_d so valids_active always matches count_q.
         va_d[j] = (count_d[j] != '0);
      end
   end

   // ------------------------------------------------------------- arbiter
   rr_arbiter #(
      .N (NSINKS)
   ) u_rr_arbiter (
      .req_i   (va_q),
      .last_i  (last_q),
      .idx_o   (rr_idx),
      .found_o (rr_found)
   );

   // The grant is held until the slave completes the transfer, even if the
   // sink's count drops to zero some other way.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            if (rr_found) begin
               state_d = BUSY;
               idx_d   = rr_idx;
            end
         end
         BUSY: begin
            if (slv0_penable) begin
               state_d = IDLE;
               last_d  = idx_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // -------------------------------------------------------- slave decode
   // Addresses above the broadcast slot match nothing and yield all zeros.
   always_comb begin
      sv_d = '0;
      for (int k = 0; k < NSOURCES; k++) begin
         sv_d[k] = slv0_wr &
                   ((paddr == ADDR_WIDTH'(k)) |
                    (is_brdcst_addr(32'(paddr), 32'(NSOURCES)) &
                     src_brdcst_subscription[k]));
      end
   end

   // ------------------------------------------------------------ registers
   // NOTE: the counter array is small and must read zero after reset, so
   // each entry is reset explicitly rather than left to power-up values.
   // NOTE: state registers use non-blocking assignment only.
   always_ff @(posedge pclk or negedge rstn) begin
      if (!rstn) begin
         mv_q    <= '0;
         for (int j = 0; j < NSINKS; j++) begin
            count_q[j] <= '0;
         end
         va_q    <= '0;
         ovf_q   <= '0;
         sv_q    <= '0;
         state_q <= IDLE;
         idx_q   <= '0;
         last_q  <= IW'(NSINKS - 1);
      end else begin
         mv_q    <= master_valids;
         for (int j = 0; j < NSINKS; j++) begin
            count_q[j] <= count_d[j];
         end
         va_q    <= va_d;
         ovf_q   <= ovf_d;
         sv_q    <= sv_d;
         state_q <= state_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
      end
   end

   assign current_idx   = idx_q;
   assign grant_valid   = (state_q == BUSY);
   assign valids_active = va_q;
   assign slave_valids  = sv_q;
   assign overflow      = ovf_q;

endmodule : valid_scheduler

// File: tb/tb_valid_scheduler.sv
// -----------------------------------------------------------------------------
// tb_valid_scheduler
// Directed-vector bench for valid_scheduler with default parameters.
// Inputs change and outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_valid_scheduler;

   localparam int NSINKS     = 4;
   localparam int NSOURCES   = 4;
   localparam int ADDR_WIDTH = 8;

   logic                  pclk = 1'b0;
   logic                  rstn;
   logic [NSINKS-1:0]     master_valids;
   logic [ADDR_WIDTH-1:0] paddr;
   logic                  slv0_wr;
   logic                  slv0_penable;
   logic [NSOURCES-1:0]   src_brdcst_subscription;
   logic                  ovf_clr;
   logic [1:0]            current_idx;
   logic                  grant_valid;
   logic [NSINKS-1:0]     valids_active;
   logic [NSOURCES-1:0]   slave_valids;
   logic [NSINKS-1:0]     overflow;

   int tests = 0;
   int fails = 0;

   always #5 pclk = ~pclk;

   valid_scheduler #(
      .NSINKS     (NSINKS),
      .NSOURCES   (NSOURCES),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (3),
      .LEVEL_MODE (0)
   ) dut (
      .pclk                    (pclk),
      .rstn                    (rstn),
      .master_valids           (master_valids),
      .paddr                   (paddr),
      .slv0_wr                 (slv0_wr),
      .slv0_penable            (slv0_penable),
      .src_brdcst_subscription (src_brdcst_subscription),
      .ovf_clr                 (ovf_clr),
      .current_idx             (current_idx),
      .grant_valid             (grant_valid),
      .valids_active           (valids_active),
      .slave_valids            (slave_valids),
      .overflow                (overflow)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic wait_grant(input string tag);
      int n = 0;
      while (!grant_valid && n < 10) begin
         tick();
         n++;
      end
      check(tag, 32'(grant_valid), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int exp_order [3] = '{3, 0, 1};

      rstn                    = 1'b0;
      master_valids           = '0;
      paddr                   = '0;
      slv0_wr                 = 1'b0;
      slv0_penable            = 1'b0;
      src_brdcst_subscription = '0;
      ovf_clr                 = 1'b0;
      tick();
      tick();

      // Reset state
      check("rst_grant", 32'(grant_valid),   32'd0);
      check("rst_idx",   32'(current_idx),   32'd0);
      check("rst_va",    32'(valids_active), 32'd0);
      check("rst_sv",    32'(slave_valids),  32'd0);
      check("rst_ovf",   32'(overflow),      32'd0);
      rstn = 1'b1;
      tick();

      // Single sink 2 request, grant two cycles later, cleared by penable
      master_valids = 4'b0100;
      tick();
      check("s2_va",       32'(valids_active), 32'h4);
      check("s2_nogrant",  32'(grant_valid),   32'd0);
      tick();
      check("s2_grant",    32'(grant_valid),   32'd1);
      check("s2_idx",      32'(current_idx),   32'd2);
      slv0_penable = 1'b1;
      tick();
      slv0_penable = 1'b0;
      master_valids = 4'b0000;
      check("s2_done_va",  32'(valids_active), 32'h0);
      check("s2_done_gnt", 32'(grant_valid),   32'd0);

      // Grant sink 1 so last_grant becomes 1, while 0,1,3 raise together
      master_valids = 4'b0010;
      tick();
      master_valids = 4'b0000;
      tick();
      check("s1_idx", 32'(current_idx), 32'd1);
      master_valids = 4'b1011;
      slv0_penable  = 1'b1;
      tick();
      // Sink 1 saw event and done together: count stays 1
      check("evdone_va",  32'(valids_active), 32'hB);
      check("evdone_gnt", 32'(grant_valid),   32'd0);
      master_valids = 4'b0000;
      slv0_penable  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rr_grant", 32'(grant_valid), 32'd1);
         check("rr_idx",   32'(current_idx), 32'(exp_order[i]));
         slv0_penable = 1'b1;
         tick();
         slv0_penable = 1'b0;
         check("rr_release", 32'(grant_valid), 32'd0);
      end
      check("rr_drained", 32'(valids_active), 32'h0);

      // Four rising edges on sink 0 with DEPTH=3 -> overflow
      for (int i = 0; i < 4; i++) begin
         master_valids = 4'b0001;
         tick();
         if (i == 2) check("ovf_before", 32'(overflow), 32'h0);
         if (i == 3) check("ovf_set",    32'(overflow), 32'h1);
         master_valids = 4'b0000;
         tick();
      end
      // Set and clear in the same cycle: set wins
      master_valids = 4'b0001;
      ovf_clr       = 1'b1;
      tick();
      check("ovf_set_wins", 32'(overflow), 32'h1);
      master_valids = 4'b0000;
      tick();
      ovf_clr = 1'b0;
      check("ovf_clr", 32'(overflow), 32'h0);
      // Count saturated at 3: exactly three completions drain sink 0
      for (int i = 0; i < 3; i++) begin
         wait_grant("drain_wait");
         check("drain_idx", 32'(current_idx), 32'd0);
         slv0_penable = 1'b1;
         tick();
         slv0_penable = 1'b0;
         check("drain_va", 32'(valids_active[0]), (i < 2) ? 32'd1 : 32'd0);
      end

      // Slave decode: broadcast, out of range, direct, idle
      src_brdcst_subscription = 4'b1010;
      slv0_wr = 1'b1;
      paddr   = 8'd4;
      tick();
      check("sv_brdcst", 32'(slave_valids), 32'hA);
      paddr = 8'd7;
      tick();
      check("sv_addr7", 32'(slave_valids), 32'h0);
      paddr = 8'd5;
      tick();
      check("sv_addr5", 32'(slave_valids), 32'h0);
      paddr = 8'd2;
      tick();
      check("sv_addr2", 32'(slave_valids), 32'h4);
      slv0_wr = 1'b0;
      tick();
      check("sv_idle", 32'(slave_valids), 32'h0);

      // Asynchronous reset while BUSY, then a held request re-arms
      master_valids = 4'b0100;
      slv0_wr       = 1'b1;
      paddr         = 8'd0;
      tick();
      tick();
      check("pre_rst_grant", 32'(grant_valid),   32'd1);
      check("pre_rst_va",    32'(valids_active), 32'h4);
      check("pre_rst_sv",    32'(slave_valids),  32'h1);
      #2;
      rstn = 1'b0;
      #1;
      check("arst_grant", 32'(grant_valid),   32'd0);
      check("arst_idx",   32'(current_idx),   32'd0);
      check("arst_va",    32'(valids_active), 32'h0);
      check("arst_sv",    32'(slave_valids),  32'h0);
      check("arst_ovf",   32'(overflow),      32'h0);
      slv0_wr = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
      check("rearm_va",    32'(valids_active), 32'h4);
      tick();
      check("rearm_grant", 32'(grant_valid),   32'd1);
      check("rearm_idx",   32'(current_idx),   32'd2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_valid_scheduler

// File: doc/valid_scheduler.md
VALID_SCHEDULER -- requirements
Module: valid_scheduler

Interface
REQ-001 SHALL have parameter NSINKS, default 4, number of master valid inputs (>=2).
REQ-002 SHALL have parameter NSOURCES, default 4, number of slave valid outputs (>=1).
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, paddr width (2^ADDR_WIDTH > NSOURCES).
REQ-004 SHALL have parameter DEPTH, default 3, max pending events per sink (>=1).
REQ-005 SHALL have parameter LEVEL_MODE, default 0: 0 = rising-edge events, 1 = level events.
REQ-006 SHALL have port pclk  in  1  clock, all state on rising edge.
REQ-007 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port master_valids  in  NSINKS  per-sink data-ready request.
REQ-009 SHALL have port paddr  in  ADDR_WIDTH  APB address of current write.
REQ-010 SHALL have port slv0_wr  in  1  write strobe to slave side.
REQ-011 SHALL have port slv0_penable  in  1  APB enable phase, marks transfer completion.
REQ-012 SHALL have port src_brdcst_subscription  in  NSOURCES  broadcast membership per source.
REQ-013 SHALL have port ovf_clr  in  1  clears all overflow flags.
REQ-014 SHALL have port current_idx  out  $clog2(NSINKS)  granted sink index.
REQ-015 SHALL have port grant_valid  out  1  current_idx is a live grant.
REQ-016 SHALL have port valids_active  out  NSINKS  sink has pending events.
REQ-017 SHALL have port slave_valids  out  NSOURCES  registered per-source write valid.
REQ-018 SHALL have port overflow  out  NSINKS  sticky pending-counter overflow.

Function
REQ-019 Event[j] SHALL be master_valids[j] & ~mv_q[j] (mv_q = master_valids delayed 1 cycle) when LEVEL_MODE=0; when LEVEL_MODE=1, master_valids[j] & ~valids_active[j].
REQ-020 Done[j] SHALL be slv0_penable & grant_valid & (current_idx==j).
REQ-021 Each sink SHALL keep a pending counter, width $clog2(DEPTH+1): +1 on event only, -1 on done only, unchanged when both or neither.
REQ-022 Event at count==DEPTH without done SHALL leave the count at DEPTH and set overflow[j]; overflow clears only on ovf_clr or reset; a simultaneous set wins over ovf_clr.
REQ-023 Done with count==0 SHALL be ignored (no underflow).
REQ-024 valids_active[j] SHALL equal (count[j]!=0), registered.
REQ-025 Arbiter FSM SHALL have states IDLE and BUSY; grant_valid=1 only in BUSY.
REQ-026 IDLE->BUSY when any valids_active bit is set: current_idx <= first active index searching from last_grant+1 upward, wrapping at NSINKS-1 to 0.
REQ-027 In BUSY, current_idx SHALL hold; on done, BUSY->IDLE, last_grant <= current_idx; re-arbitration occurs the following cycle.
REQ-028 If the granted sink's count reaches 0 by any other means, the FSM SHALL remain in BUSY until done.
REQ-029 slave_valids[k] SHALL register 1 in the cycle after slv0_wr=1 with paddr==k, or with paddr==NSOURCES and src_brdcst_subscription[k]=1; otherwise 0.
REQ-030 paddr > NSOURCES with slv0_wr SHALL drive all slave_valids 0.

Reset
REQ-031 rstn low SHALL asynchronously clear mv_q, counters, overflow, slave_valids, current_idx, and last_grant to NSINKS-1, and force IDLE; this applies mid-transfer too.
REQ-032 In the first cycle after reset release, a master_valids bit already high SHALL generate an event in both modes.

Structure
REQ-033 A shared package SHALL hold the FSM state enum and the broadcast-address helper (NSOURCES as broadcast index).
REQ-034 The round-robin index search SHALL be a sub-module rr_arbiter (NSINKS-parameterised, request vector plus last grant in, index plus found out).

Verification
REQ-035 Sink 2 rises while others idle -> count[2]=1, grant_valid with current_idx=2 two cycles later; penable -> valids_active[2]=0.
REQ-036 Sinks 0,1,3 active with last_grant=1 -> grant order 3,0,1.
REQ-037 DEPTH=3, four rising edges on sink 0 with no penable -> count 3, overflow[0]=1; ovf_clr -> 0.
REQ-038 Event and done on the granted sink in the same cycle with count 1 -> count stays 1, valids_active stays 1.
REQ-039 paddr=NSOURCES with subscription 4'b1010 and slv0_wr -> slave_valids=4'b1010 next cycle; paddr=7 -> 0.
REQ-040 rstn pulsed low while BUSY with counts nonzero -> all outputs 0 and FSM IDLE immediately; a master_valids bit held high re-arms after release.
